brom_arbiter: RTL and testbench
===============================

# brom_arbiter

Two-port arbiter and response sequencer for the single-port synchronous instruction/data ROM (`brom`). It sits between the ROM and two requesters, port 0 (instruction fetch / I-cache refill) and port 1 (data load). It grants at most one ROM read per cycle, routes the one-cycle-late ROM data to the owning port, and holds that data when the port applies back-pressure.

## Interface
- `AWIDTH`, default 10: ROM word-address width.
- `DWIDTH`, default 32: ROM data width.
- `clk`  in  1  system clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `req0_valid` / `req1_valid`  in  1  read request from port 0 / port 1.
- `req0_addr` / `req1_addr`  in  AWIDTH  word address; must be stable while valid.
- `req0_ready` / `req1_ready`  out  1  grant; the request is accepted in any cycle where valid and ready are both 1.
- `rsp0_valid` / `rsp1_valid`  out  1  read data available.
- `rsp0_data` / `rsp1_data`  out  DWIDTH  read data.
- `rsp0_ready` / `rsp1_ready`  in  1  consumer accepts the response in this cycle.
- `rom_cs`  out  1  ROM read enable.
- `rom_addr`  out  AWIDTH  ROM address.
- `rom_dout`  in  DWIDTH  ROM registered output; valid the cycle after `rom_cs`; held while `rom_cs` is 0.

## Operation
- Per-port response FSM with states IDLE, READ and HOLD. Reset state is IDLE.
  - IDLE: `rspN_valid` = 0.
  - READ: `rspN_valid` = 1, `rspN_data` = `rom_dout`.
  - HOLD: `rspN_valid` = 1, `rspN_data` = the port's hold register.
- Port N is eligible when `reqN_valid` = 1 and either its state is IDLE, or its state is READ/HOLD with `rspN_ready` = 1.
- Grant is combinational from eligibility, with at most one grant per cycle.
  - `rom_cs` = OR of the grants.
  - `rom_addr` = the granted address, or 0 when nothing is granted.
  - `reqN_ready` = grantN.
- Transitions on each clock edge:
  - Granted: state goes to READ, regardless of the current state (a response accepted and a new request granted in the same cycle gives READ → READ).
  - READ, not granted, `rspN_ready` = 1: state goes to IDLE.
  - READ, `rspN_ready` = 0: capture `rom_dout` into the hold register; state goes to HOLD.
  - HOLD, not granted, `rspN_ready` = 1: state goes to IDLE.
  - HOLD, `rspN_ready` = 0: stay in HOLD; the hold register is unchanged.
- A held response is never overwritten. A port in HOLD or READ that is not accepting its response cannot be granted.
- Arbitration when both ports are eligible is set by the configuration macro below.
  - A `last` flop records the most recently granted port.
  - `last` resets to 1, so port 0 wins the first contest.
  - `last` updates only on a grant.
- Address width passes straight through; there is no arithmetic and no wrap-around logic. Out-of-range addresses are the ROM's concern.

## Timing
- Read latency is 1 cycle: a request accepted in cycle N gives `rspN_valid` = 1 with correct data in cycle N+1.
- Throughput: one ROM read per cycle in aggregate. A single port with `rsp_ready` tied to 1 gets back-to-back reads every cycle.
- Reset values:
  - all `rsp*_valid` = 0 and all states IDLE;
  - hold registers = 0; `last` = 1.
- While `rst` = 1, all grants are forced to 0, so `rom_cs` = 0 and all `req*_ready` = 0.
- Reset mid-operation: outstanding READ/HOLD responses are dropped, with no `rsp_valid` in the cycle after reset deasserts. Requests presented during reset are not accepted.
- Combinational paths:
  - `req*_valid` / `rsp*_ready` → `req*_ready` / `rom_cs` / `rom_addr`;
  - `rom_dout` → `rsp*_data` in READ.
  - Requesters must not make `req_valid` depend on `req_ready`.

## Configuration
- `BROM_ARB_RR_EN` defined: round-robin. When both ports are eligible, grant the port that is not `last`.
- Undefined: fixed priority. Port 0 always wins a contest. The `last` flop is still present and still updated, but it does not affect the grant.

## Test plan
- Single read: ROM word 5 = 0xDEADBEEF; port 0 requests addr 5 in cycle 1 with `rsp0_ready` = 1 → `rom_cs` = 1 and `rom_addr` = 5 in cycle 1; `rsp0_valid` = 1 with 0xDEADBEEF in cycle 2; `rsp0_valid` = 0 in cycle 3.
- Contention with `BROM_ARB_RR_EN`: both ports valid continuously with ready = 1 → grants alternate 0,1,0,1. Without the macro → port 0 is granted every cycle and `req1_ready` stays 0.
- Back-pressure: port 1 reads addr 3 (0x11111111) with `rsp1_ready` = 0 for 4 cycles while port 0 reads addrs 4–7 → `rsp1_data` stays 0x11111111 throughout; port 1 is not granted until `rsp1_ready` = 1.
- Streaming: port 0 reads addrs 0–7 on consecutive cycles with ready = 1 → 8 consecutive `rsp0_valid` cycles with data in address order.
- Reset mid-operation: assert `rst` in the cycle a port is in READ and the other is in HOLD → both `rsp_valid` = 0 immediately; `rom_cs` = 0 during reset; after release, the first contest is won by port 0.

Source files
------------

// File: rtl/brom_arbiter.sv
// Two-port arbiter and response sequencer for the single-port synchronous ROM.
// Define BROM_ARB_RR_EN for round-robin arbitration; the default is fixed priority (port 0 wins).
module brom_arbiter #(
    parameter int AWIDTH = 10,
    parameter int DWIDTH = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [AWIDTH-1:0] req0_addr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [AWIDTH-1:0] req1_addr,
    output logic              req1_ready,
    output logic              rsp0_valid,
    output logic [DWIDTH-1:0] rsp0_data,
    input  logic              rsp0_ready,
    output logic              rsp1_valid,
    output logic [DWIDTH-1:0] rsp1_data,
    input  logic              rsp1_ready,
    output logic              rom_cs,
    output logic [AWIDTH-1:0] rom_addr,
    input  logic [DWIDTH-1:0] rom_dout
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        HOLD = 2'd2
    } state_e;

    state_e            st0_q, st0_d, st1_q, st1_d;
    logic [DWIDTH-1:0] hold0_q, hold0_d, hold1_q, hold1_d;
    logic              last_q, last_d;
    logic              elig0, elig1, gnt0, gnt1;

    function automatic state_e next_state(input state_e s, input logic g, input logic r);
        state_e n;
        n = IDLE;
        if (g) begin
            n = READ;
        end else begin
            case (s)
                READ:    n = r ? IDLE : HOLD;
                HOLD:    n = r ? IDLE : HOLD;
                default: n = IDLE;
            endcase
        end
        return n;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st0_q   <= IDLE;
            st1_q   <= IDLE;
            hold0_q <= '0;
            hold1_q <= '0;
            last_q  <= 1'b1;
        end else begin
            st0_q   <= st0_d;
            st1_q   <= st1_d;
            hold0_q <= hold0_d;
            hold1_q <= hold1_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        elig0 = req0_valid && ((st0_q == IDLE) || rsp0_ready);
        elig1 = req1_valid && ((st1_q == IDLE) || rsp1_ready);
        gnt0  = 1'b0;
        gnt1  = 1'b0;
        if (!rst) begin
`ifdef BROM_ARB_RR_EN
            if (elig0 && elig1) begin
                gnt0 = last_q;
                gnt1 = ~last_q;
            end else begin
                gnt0 = elig0;
                gnt1 = elig1;
            end
`else
            gnt0 = elig0;
            gnt1 = elig1 && !elig0;
`endif
        end
    end

    always_comb begin
        st0_d   = next_state(st0_q, gnt0, rsp0_ready);
        st1_d   = next_state(st1_q, gnt1, rsp1_ready);
        hold0_d = hold0_q;
        hold1_d = hold1_q;
        // rom_dout may be overwritten by the other port's read next cycle, so stalled data is captured
        if (st0_q == READ && !rsp0_ready) hold0_d = rom_dout;
        if (st1_q == READ && !rsp1_ready) hold1_d = rom_dout;
        last_d = last_q;
        if (gnt0)      last_d = 1'b0;
        else if (gnt1) last_d = 1'b1;
    end

    always_comb begin
        req0_ready = gnt0;
        req1_ready = gnt1;
        rom_cs     = gnt0 | gnt1;
        rom_addr   = '0;
        if (gnt0)      rom_addr = req0_addr;
        else if (gnt1) rom_addr = req1_addr;
        rsp0_valid = (st0_q != IDLE);
        rsp1_valid = (st1_q != IDLE);
        rsp0_data  = (st0_q == READ) ? rom_dout : hold0_q;
        rsp1_data  = (st1_q == READ) ? rom_dout : hold1_q;
    end

endmodule

// File: tb/tb_brom_arbiter.sv
// Scoreboard bench for brom_arbiter: a ROM model, a grant/response reference model and
// directed plus random stimulus.
module tb_brom_arbiter;
    localparam int AW = 10;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req1_valid, req0_ready, req1_ready;
    logic [AW-1:0] req0_addr, req1_addr, rom_addr;
    logic          rsp0_valid, rsp1_valid, rsp0_ready, rsp1_ready;
    logic [DW-1:0] rsp0_data, rsp1_data;
    logic          rom_cs;
    logic [DW-1:0] rom_dout = '0;
    logic [DW-1:0] mem [0:(1<<AW)-1];

    int unsigned tests = 0;
    int unsigned fails = 0;

    // reference model state
    logic [DW-1:0] q0[$], q1[$];
    bit            last_m = 1'b1;
    bit            g0m = 1'b0, g1m = 1'b0;
    logic [AW-1:0] a0m, a1m;

    brom_arbiter #(.AWIDTH(AW), .DWIDTH(DW)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_addr(req0_addr), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_addr(req1_addr), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_data(rsp0_data), .rsp0_ready(rsp0_ready),
        .rsp1_valid(rsp1_valid), .rsp1_data(rsp1_data), .rsp1_ready(rsp1_ready),
        .rom_cs(rom_cs), .rom_addr(rom_addr), .rom_dout(rom_dout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (rom_cs) rom_dout <= mem[rom_addr];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // monitor: reference grants and response checks, sampled mid-cycle
    always @(negedge clk) begin
        bit e0, e1, x0, x1;
        logic [AW-1:0] xa;
        if (rst) begin
            chk("rst_req0_ready", req0_ready, 0);
            chk("rst_req1_ready", req1_ready, 0);
            chk("rst_rom_cs", rom_cs, 0);
            chk("rst_rsp0_valid", rsp0_valid, 0);
            chk("rst_rsp1_valid", rsp1_valid, 0);
            q0.delete();
            q1.delete();
            last_m = 1'b1;
            g0m = 1'b0;
            g1m = 1'b0;
        end else begin
            // a port may take a new grant only if it has no pending response or is accepting it now
            e0 = req0_valid && (q0.size() == 0 || rsp0_ready);
            e1 = req1_valid && (q1.size() == 0 || rsp1_ready);
            x0 = e0;
            x1 = e1;
            if (e0 && e1) begin
`ifdef BROM_ARB_RR_EN
                x0 = last_m;
                x1 = !last_m;
`else
                x0 = 1'b1;
                x1 = 1'b0;
`endif
            end
            xa = x0 ? req0_addr : (x1 ? req1_addr : '0);
            chk("req0_ready", req0_ready, x0);
            chk("req1_ready", req1_ready, x1);
            chk("rom_cs", rom_cs, x0 | x1);
            chk("rom_addr", rom_addr, xa);
            if (q0.size() != 0) begin
                chk("rsp0_valid", rsp0_valid, 1);
                chk("rsp0_data", rsp0_data, q0[0]);
                if (rsp0_ready) void'(q0.pop_front());
            end else begin
                chk("rsp0_valid_idle", rsp0_valid, 0);
            end
            if (q1.size() != 0) begin
                chk("rsp1_valid", rsp1_valid, 1);
                chk("rsp1_data", rsp1_data, q1[0]);
                if (rsp1_ready) void'(q1.pop_front());
            end else begin
                chk("rsp1_valid_idle", rsp1_valid, 0);
            end
            if (x0) last_m = 1'b0;
            else if (x1) last_m = 1'b1;
            g0m = x0;
            g1m = x1;
            a0m = req0_addr;
            a1m = req1_addr;
        end
    end

    // scoreboard push: an accepted request owes its port the ROM word next cycle
    always @(negedge clk) begin
        #1;
        if (g0m) q0.push_back(mem[a0m]);
        if (g1m) q1.push_back(mem[a1m]);
    end

    task automatic cyc(input bit r, input bit v0, input int a0, input bit rr0,
                       input bit v1, input int a1, input bit rr1);
        @(posedge clk);
        #1;
        rst        = r;
        req0_valid = v0;
        req0_addr  = AW'(a0);
        rsp0_ready = rr0;
        req1_valid = v1;
        req1_addr  = AW'(a1);
        rsp1_ready = rr1;
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++) mem[i] = $urandom;
        mem[5] = 32'hDEADBEEF;
        mem[3] = 32'h11111111;
        rst = 1'b1;
        req0_valid = 1'b1; req0_addr = '0; rsp0_ready = 1'b1;
        req1_valid = 1'b1; req1_addr = '0; rsp1_ready = 1'b1;

        // reset with requests present: none accepted
        repeat (3) cyc(1, 1, 1, 1, 1, 2, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);

        // single read of word 5
        cyc(0, 1, 5, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        chk("single_read_data", rsp0_data, 32'hDEADBEEF);
        cyc(0, 0, 0, 1, 0, 0, 1);

        // contention, both always ready
        for (int i = 0; i < 6; i++) cyc(0, 1, 16 + i, 1, 1, 32 + i, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);

        // back-pressure on port 1 while port 0 streams 4..7
        cyc(0, 0, 0, 1, 1, 3, 0);
        for (int i = 4; i < 8; i++) cyc(0, 1, i, 1, 1, 8, 0);
        @(negedge clk);
        chk("held_rsp1_data", rsp1_data, 32'h11111111);
        cyc(0, 0, 0, 1, 1, 8, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);

        // streaming 0..7 on port 0
        for (int i = 0; i < 8; i++) cyc(0, 1, i, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);

        // reset with port 0 in READ and port 1 in HOLD
        cyc(0, 0, 0, 1, 1, 9, 0);
        cyc(0, 1, 2, 1, 0, 0, 0);
        cyc(1, 1, 11, 1, 1, 12, 1);
        cyc(1, 1, 11, 1, 1, 12, 1);
        cyc(0, 1, 11, 1, 1, 12, 1);
        @(negedge clk);
        chk("post_reset_first_winner", req0_ready, 1);
        for (int i = 0; i < 3; i++) cyc(0, 1, 40 + i, 1, 1, 50 + i, 1);

        // random traffic; a stalled request keeps its address
        for (int n = 0; n < 400; n++) begin
            bit r, v0, v1;
            int a0, a1;
            r  = ($urandom_range(0, 99) == 0);
            v0 = $urandom_range(0, 1);
            v1 = $urandom_range(0, 1);
            a0 = $urandom_range(0, (1 << AW) - 1);
            a1 = $urandom_range(0, (1 << AW) - 1);
            if (req0_valid && !g0m && !rst) begin v0 = 1'b1; a0 = int'(req0_addr); end
            if (req1_valid && !g1m && !rst) begin v1 = 1'b1; a1 = int'(req1_addr); end
            cyc(r, v0, a0, ($urandom_range(0, 3) != 0), v1, a1, ($urandom_range(0, 3) != 0));
        end
        cyc(0, 0, 0, 1, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0, 1);
        @(negedge clk);
        #2;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
